// File: rtl/layer_frame_sched_if.sv
// rtl/layer_frame_sched_if.sv - host write/frame bus shared by the layer frame scheduler
interface layer_frame_sched_if #(
  parameter int LAYERS  = 8,
  parameter int LAYER_W = 3
) ();
  logic               wr_vld_in;
  logic [LAYER_W-1:0] wr_layer_in;
  logic [5:0]         wr_addr_in;
  logic [3:0]         byte_en_in;
  logic [7:0]         byte_data_in;
  logic               frame_end_in;
  logic [LAYERS-1:0]  layer_en_out;
  logic [5:0]         wr_addr_out;
  logic [3:0]         byte_en_out;
  logic [7:0]         byte_data_out;
  logic               frame_rdy_out;
  logic               busy_out;
  logic [7:0]         drop_cnt_out;

  modport master (
    output wr_vld_in, wr_layer_in, wr_addr_in, byte_en_in, byte_data_in, frame_end_in,
    input  layer_en_out, wr_addr_out, byte_en_out, byte_data_out,
    input  frame_rdy_out, busy_out, drop_cnt_out
  );

  modport slave (
    input  wr_vld_in, wr_layer_in, wr_addr_in, byte_en_in, byte_data_in, frame_end_in,
    output layer_en_out, wr_addr_out, byte_en_out, byte_data_out,
    output frame_rdy_out, busy_out, drop_cnt_out
  );
endinterface

// File: rtl/layer_frame_sched.sv
// rtl/layer_frame_sched.sv - layer write decoder and rate-limited frame_rdy broadcaster
module layer_frame_sched #(
  parameter int LAYERS       = 8,
  parameter int LAYER_W      = 3,
  parameter int MIN_PERIOD   = 2000000,
  parameter int AUTO_REFRESH = 0,
  parameter int CNT_W        = 32
) (
  input logic                clk_in,
  input logic                rst_in,
  layer_frame_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FIRE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   MIN_P    = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]   AUTO_P   = CNT_W'(AUTO_REFRESH);
  localparam logic [LAYER_W:0]   LAYERS_L = (LAYER_W + 1)'(LAYERS);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             ok;
  logic             auto_due;
  logic             drop_inc;
  logic             layer_ok;

  assign ok       = (cnt >= MIN_P);
  assign auto_due = (AUTO_REFRESH != 0) && (cnt >= AUTO_P);
  assign layer_ok = bus.wr_vld_in && ({1'b0, bus.wr_layer_in} < LAYERS_L);

  // Write path runs every cycle regardless of the frame FSM.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bus.layer_en_out  <= '0;
      bus.byte_en_out   <= '0;
      bus.wr_addr_out   <= '0;
      bus.byte_data_out <= '0;
    end else begin
      bus.wr_addr_out   <= bus.wr_addr_in;
      bus.byte_data_out <= bus.byte_data_in;
      if (layer_ok) begin
        bus.layer_en_out <= LAYERS'(1) << bus.wr_layer_in;
        bus.byte_en_out  <= bus.byte_en_in;
      end else begin
        bus.layer_en_out <= '0;
        bus.byte_en_out  <= '0;
      end
    end
  end

  // cnt reads 0 during the FIRE cycle, so a HOLD releases MIN_PERIOD+1 cycles after the pulse.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= IDLE;
      cnt              <= MIN_P;
      bus.drop_cnt_out <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == FIRE) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_ONE;
      end
      if (drop_inc && (bus.drop_cnt_out != 8'hFF)) begin
        bus.drop_cnt_out <= bus.drop_cnt_out + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt         = state;
    drop_inc          = 1'b0;
    bus.frame_rdy_out = 1'b0;
    bus.busy_out      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.frame_end_in) begin
          state_nxt = ok ? FIRE : HOLD;
        end else if (auto_due) begin
          state_nxt = FIRE;
        end
      end
      HOLD: begin
        bus.busy_out = 1'b1;
        if (ok) begin
          state_nxt = FIRE;
        end else if (bus.frame_end_in) begin
          drop_inc = 1'b1;
        end
      end
      FIRE: begin
        bus.frame_rdy_out = 1'b1;
        state_nxt = bus.frame_end_in ? HOLD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_layer_frame_sched.sv
// tb/tb_layer_frame_sched.sv - directed checks of layer_frame_sched write decode and frame pacing
module tb_layer_frame_sched;

  logic clk = 1'b0;
  logic rst;
  logic rst_ar;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   n, k, p;

  always #5 clk = ~clk;

  layer_frame_sched_if #(.LAYERS(8), .LAYER_W(4)) bus ();
  layer_frame_sched_if #(.LAYERS(8), .LAYER_W(3)) bus_ar ();

  layer_frame_sched #(
    .LAYERS(8), .LAYER_W(4), .MIN_PERIOD(100), .AUTO_REFRESH(0), .CNT_W(16)
  ) u_dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  layer_frame_sched #(
    .LAYERS(8), .LAYER_W(3), .MIN_PERIOD(100), .AUTO_REFRESH(250), .CNT_W(16)
  ) u_dut_ar (
    .clk_in (clk),
    .rst_in (rst_ar),
    .bus    (bus_ar)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pulse(input bit ar, input int max, output int cnt_o);
    cnt_o = 0;
    do begin
      tick();
      cnt_o++;
    end while (((ar ? bus_ar.frame_rdy_out : bus.frame_rdy_out) !== 1'b1) && (cnt_o <= max));
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.frame_rdy_out === 1'b1) pulses++;
    end
  endtask

  task automatic set_wr(input logic v, input logic [3:0] l, input logic [5:0] a,
                        input logic [3:0] be, input logic [7:0] d);
    bus.wr_vld_in    = v;
    bus.wr_layer_in  = l;
    bus.wr_addr_in   = a;
    bus.byte_en_in   = be;
    bus.byte_data_in = d;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst    = 1'b1;
    rst_ar = 1'b1;
    set_wr(1'b0, 4'd0, 6'd0, 4'd0, 8'd0);
    bus.frame_end_in      = 1'b0;
    bus_ar.wr_vld_in      = 1'b0;
    bus_ar.wr_layer_in    = '0;
    bus_ar.wr_addr_in     = '0;
    bus_ar.byte_en_in     = '0;
    bus_ar.byte_data_in   = '0;
    bus_ar.frame_end_in   = 1'b0;
    repeat (3) tick();

    chk("rst_layer_en", bus.layer_en_out, 0);
    chk("rst_byte_en", bus.byte_en_out, 0);
    chk("rst_addr", bus.wr_addr_out, 0);
    chk("rst_data", bus.byte_data_out, 0);
    chk("rst_frame_rdy", bus.frame_rdy_out, 0);
    chk("rst_busy", bus.busy_out, 0);
    chk("rst_drop", bus.drop_cnt_out, 0);
    rst = 1'b0;
    tick();

    // Write decode: layers 0..7 valid, 8 and 9 discarded.
    for (int l = 0; l < 10; l++) begin
      set_wr(1'b1, 4'(l), 6'd5, 4'b0010, 8'hA5);
      tick();
      chk($sformatf("wr_layer_en_%0d", l), bus.layer_en_out, (l < 8) ? (32'd1 << l) : 32'd0);
      chk($sformatf("wr_byte_en_%0d", l), bus.byte_en_out, (l < 8) ? 32'h2 : 32'h0);
      chk($sformatf("wr_addr_%0d", l), bus.wr_addr_out, 5);
      chk($sformatf("wr_data_%0d", l), bus.byte_data_out, 32'hA5);
    end
    set_wr(1'b0, 4'd3, 6'd9, 4'hF, 8'h5A);
    tick();
    chk("novld_layer_en", bus.layer_en_out, 0);
    chk("novld_byte_en", bus.byte_en_out, 0);
    chk("novld_addr", bus.wr_addr_out, 9);
    chk("novld_data", bus.byte_data_out, 32'h5A);

    // First frame fires immediately; second is held off to 101 cycles.
    bus.frame_end_in = 1'b1;
    tick();
    bus.frame_end_in = 1'b0;
    chk("first_pulse", bus.frame_rdy_out, 1);
    tick();
    chk("first_pulse_width", bus.frame_rdy_out, 0);
    repeat (18) tick();
    bus.frame_end_in = 1'b1;
    tick();
    bus.frame_end_in = 1'b0;
    chk("hold_busy", bus.busy_out, 1);
    wait_pulse(1'b0, 200, n);
    chk("second_spacing", 20 + n, 101);
    chk("fire_not_busy", bus.busy_out, 0);
    chk("no_drop_yet", bus.drop_cnt_out, 0);

    // Three frame_end events in one HOLD merge into one pulse, two drops.
    repeat (4) tick();
    bus.frame_end_in = 1'b1; tick(); bus.frame_end_in = 1'b0;
    tick();
    bus.frame_end_in = 1'b1; tick(); bus.frame_end_in = 1'b0;
    tick();
    bus.frame_end_in = 1'b1; tick(); bus.frame_end_in = 1'b0;
    chk("merge_busy", bus.busy_out, 1);
    chk("merge_drop", bus.drop_cnt_out, 2);
    wait_pulse(1'b0, 200, n);
    chk("merge_spacing", 9 + n, 101);

    // frame_end during FIRE goes straight to HOLD without a drop.
    bus.frame_end_in = 1'b1;
    tick();
    bus.frame_end_in = 1'b0;
    chk("fire_coinc_busy", bus.busy_out, 1);
    chk("fire_coinc_drop", bus.drop_cnt_out, 2);
    wait_pulse(1'b0, 200, n);
    chk("fire_coinc_spacing", 1 + n, 101);
    count_pulses(150, p);
    chk("single_pulse_after", p, 0);

    // Hold frame_end high long enough for several hundred merges.
    bus.frame_end_in = 1'b1;
    repeat (450) tick();
    bus.frame_end_in = 1'b0;
    chk("drop_saturate", bus.drop_cnt_out, 255);
    repeat (3) tick();
    chk("drop_stays", bus.drop_cnt_out, 255);

    // Reset while HOLD abandons the frame; the next one fires at once.
    wait_pulse(1'b0, 200, n);
    chk("pre_reset_pulse", bus.frame_rdy_out, 1);
    bus.frame_end_in = 1'b1;
    tick();
    bus.frame_end_in = 1'b0;
    chk("pre_reset_busy", bus.busy_out, 1);
    rst = 1'b1;
    set_wr(1'b1, 4'd1, 6'd3, 4'h1, 8'h11);
    tick();
    chk("mid_rst_frame_rdy", bus.frame_rdy_out, 0);
    chk("mid_rst_busy", bus.busy_out, 0);
    chk("mid_rst_drop", bus.drop_cnt_out, 0);
    chk("mid_rst_layer_en", bus.layer_en_out, 0);
    chk("mid_rst_addr", bus.wr_addr_out, 0);
    rst = 1'b0;
    set_wr(1'b1, 4'd2, 6'd7, 4'hF, 8'h3C);
    bus.frame_end_in = 1'b1;
    tick();
    bus.frame_end_in = 1'b0;
    set_wr(1'b0, 4'd0, 6'd0, 4'd0, 8'd0);
    chk("post_rst_pulse", bus.frame_rdy_out, 1);
    chk("coinc_layer_en", bus.layer_en_out, 32'h4);
    chk("coinc_byte_en", bus.byte_en_out, 32'hF);
    chk("coinc_data", bus.byte_data_out, 32'h3C);

    // Keep-alive refresh on the AUTO_REFRESH=250 instance.
    rst_ar = 1'b0;
    wait_pulse(1'b1, 400, n);
    chk("ar_first", n, 151);
    wait_pulse(1'b1, 400, n);
    chk("ar_period_1", n, 251);
    wait_pulse(1'b1, 400, n);
    chk("ar_period_2", n, 251);
    repeat (150) tick();
    bus_ar.frame_end_in = 1'b1;
    tick();
    bus_ar.frame_end_in = 1'b0;
    chk("ar_host_pulse", bus_ar.frame_rdy_out, 1);
    wait_pulse(1'b1, 400, n);
    chk("ar_restart", n, 251);
    k = n_fail;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
